// File: rtl/jzjpcc_ex_mem_buffer.sv
// Execute-to-memory pipeline FIFO with a valid/ready handshake.
// Store lane alignment, byte mask and misalignment are resolved at push time.
module jzjpcc_ex_mem_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_aluResult,
  input  logic [XLEN-1:0]       in_storeData,
  input  logic [4:0]            in_rdAddr,
  input  logic [2:0]            in_funct3,
  input  logic                  in_memWrite,
  input  logic                  in_rdSource,
  input  logic                  in_rdWriteEnable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-$clog2(XLEN/8)-1:0] out_memAddress,
  output logic [XLEN-1:0]       out_memDataToWrite,
  output logic [XLEN/8-1:0]     out_memByteMask,
  output logic                  out_memoryWriteEnable,
  output logic [XLEN-1:0]       out_aluResult,
  output logic [4:0]            out_rdAddr,
  output logic                  out_rdSource,
  output logic                  out_rdWriteEnable,
  output logic [2:0]            out_funct3,
  output logic                  out_misaligned,
  output logic [2:0]            occupancy
);

  localparam int LANES = XLEN / 8;
  localparam int LSB   = $clog2(LANES);

  typedef struct packed {
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  data;
    logic [LANES-1:0] mask;
    logic [4:0]       rd;
    logic [2:0]       f3;
    logic             mw;
    logic             rs;
    logic             rwe;
    logic             mis;
  } ent_t;

  ent_t       mem_q [4];
  ent_t       ent_d;
  ent_t       head;
  logic [1:0] wr_q, wr_d;
  logic [1:0] rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       push, pop;
  logic [LSB-1:0] a;

  function automatic logic [1:0] inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign out_valid = (cnt_q != 3'd0);
  assign in_ready  = (cnt_q != 3'(DEPTH)) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign a         = in_aluResult[LSB-1:0];

  always_comb begin
    ent_d      = '0;
    ent_d.alu  = in_aluResult;
    ent_d.rd   = in_rdAddr;
    ent_d.f3   = in_funct3;
    ent_d.mw   = in_memWrite;
    ent_d.rs   = in_rdSource;
    ent_d.rwe  = in_rdWriteEnable;
    unique case (in_funct3[1:0])
      2'b00: begin
        ent_d.mask = LANES'(1) << a;
        ent_d.data = {LANES{in_storeData[7:0]}};
      end
      2'b01: begin
        ent_d.mask = LANES'(3) << a;
        ent_d.data = {(LANES/2){in_storeData[15:0]}};
        ent_d.mis  = a[0];
      end
      2'b10: begin
        // Wide datapath places a word on a 4-byte lane boundary.
        if (XLEN == 64)
          ent_d.mask = LANES'(8'h0F) << {a[LSB-1], 2'b00};
        else
          ent_d.mask = LANES'(4'hF) << a;
        ent_d.data = {(LANES/4){in_storeData[31:0]}};
        ent_d.mis  = (a[1:0] != 2'b00);
      end
      default: begin
        ent_d.mask = '1;
        ent_d.data = in_storeData;
        ent_d.mis  = (XLEN == 32) ? 1'b1 : (a != '0);
      end
    endcase
    if (!in_memWrite) begin
      ent_d.data = '0;
      ent_d.mis  = 1'b0;
    end
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = inc(wr_q);
    if (pop)  rd_d = inc(rd_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wr_q] <= ent_d;
    end
  end

  assign head                  = mem_q[rd_q];
  assign occupancy             = cnt_q;
  assign out_memAddress        = head.alu[XLEN-1:LSB];
  assign out_memDataToWrite    = head.data;
  assign out_memByteMask       = head.mask;
  assign out_memoryWriteEnable = out_valid && head.mw && !head.mis;
  assign out_aluResult         = head.alu;
  assign out_rdAddr            = head.rd;
  assign out_rdSource          = head.rs;
  assign out_rdWriteEnable     = out_valid && head.rwe;
  assign out_funct3            = head.f3;
  assign out_misaligned        = head.mis;

endmodule
